// File: rtl/parity_gen_chk_fifo.sv
// parity_gen_chk_fifo
//   Streaming parity generator/checker feeding a DEPTH-entry output FIFO.
//   Each accepted word is either framed with a parity bit at the MSB (generate
//   mode) or passed through with its frame parity verified (check mode).
//   Parity/error are resolved at push time and stored with the entry.
//
// Ports
//   clk, rst             clock (rising edge), asynchronous active-high reset
//   chk_mode, odd_sel    per-word mode (0 gen / 1 check) and parity (0 even / 1 odd)
//   in_valid/in_ready    input handshake, in_data is {parity, payload} (parity
//                        bit ignored in generate mode)
//   out_valid/out_ready  output handshake, out_data/out_err describe FIFO head
//   err_count, err_clr   saturating check-error counter and its sync clear
//   level                current FIFO occupancy
module parity_gen_chk_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       chk_mode,
    input  logic                       odd_sel,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH:0]             in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH:0]             out_data,
    output logic                       out_err,
    output logic [CNT_W-1:0]           err_count,
    input  logic                       err_clr,
    output logic [$clog2(DEPTH+1)-1:0] level
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = $clog2(DEPTH + 1);

    // Each entry holds {err, frame}
    logic [WIDTH+1:0]   mem_q [DEPTH];
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]      level_q, level_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               push, pop;
    logic [WIDTH:0]     frame;
    logic               frame_err;

    assign in_ready  = (level_q != LW'(DEPTH));
    assign out_valid = (level_q != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    always_comb begin
        frame     = '0;
        frame_err = 1'b0;
        if (chk_mode) begin
            frame     = in_data;
            frame_err = (^in_data) ^ odd_sel;
        end else begin
            frame     = {(^in_data[WIDTH-1:0]) ^ odd_sel, in_data[WIDTH-1:0]};
            frame_err = 1'b0;
        end
    end

    // Pointer width equals log2(DEPTH), so the increment wraps naturally
    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        level_d  = level_q;
        unique case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    // Clear wins over a same-cycle increment; increment stops at all-ones
    always_comb begin
        cnt_d = cnt_q;
        if (err_clr) begin
            cnt_d = '0;
        end else if (push && frame_err && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            cnt_q    <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            cnt_q    <= cnt_d;
            if (push) begin
                mem_q[wr_ptr_q] <= {frame_err, frame};
            end
        end
    end

    // Head is only exposed while the FIFO holds something
    always_comb begin
        out_data = '0;
        out_err  = 1'b0;
        if (out_valid) begin
            out_data = mem_q[rd_ptr_q][WIDTH:0];
            out_err  = mem_q[rd_ptr_q][WIDTH+1];
        end
    end

    assign err_count = cnt_q;
    assign level     = level_q;

endmodule

// File: tb/tb_parity_gen_chk_fifo.sv
// Directed testbench for parity_gen_chk_fifo (WIDTH=8, DEPTH=4, CNT_W=2 so
// that saturation is reachable with a handful of words).
module tb_parity_gen_chk_fifo;

    logic       clk = 1'b0;
    logic       rst;
    logic       chk_mode, odd_sel, in_valid, in_ready;
    logic [8:0] in_data;
    logic       out_valid, out_ready;
    logic [8:0] out_data;
    logic       out_err;
    logic [1:0] err_count;
    logic       err_clr;
    logic [2:0] level;

    int n_checks = 0;
    int n_errors = 0;

    parity_gen_chk_fifo #(
        .WIDTH(8),
        .DEPTH(4),
        .CNT_W(2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .chk_mode (chk_mode),
        .odd_sel  (odd_sel),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_err  (out_err),
        .err_count(err_count),
        .err_clr  (err_clr),
        .level    (level)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One-cycle push; returns #1 after the capturing edge with in_valid low
    task automatic push_one(input logic cm, input logic odd, input logic [8:0] d);
        chk_mode = cm;
        odd_sel  = odd;
        in_data  = d;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Push with out_ready=1, check the head one cycle later, then let it drain
    task automatic push_and_see(input string tag, input logic cm, input logic odd,
                                input logic [8:0] d, input logic [8:0] exp_data,
                                input logic exp_err);
        push_one(cm, odd, d);
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_data"}, 32'(out_data), 32'(exp_data));
        check({tag, "_err"}, 32'(out_err), 32'(exp_err));
        @(posedge clk);
        #1;
    endtask

    logic [8:0] words [5];
    logic [8:0] exp_w [5];

    initial begin
        words[0] = 9'h011; exp_w[0] = 9'h011;
        words[1] = 9'h012; exp_w[1] = 9'h012;
        words[2] = 9'h013; exp_w[2] = 9'h113;
        words[3] = 9'h014; exp_w[3] = 9'h014;
        words[4] = 9'h015; exp_w[4] = 9'h115;

        rst = 1'b1; chk_mode = 1'b0; odd_sel = 1'b0; in_valid = 1'b0;
        in_data = '0; out_ready = 1'b1; err_clr = 1'b0;
        #12;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_level", 32'(level), 32'd0);
        check("rst_err_count", 32'(err_count), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_err", 32'(out_err), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Generate mode
        push_and_see("gen_a5_even", 1'b0, 1'b0, 9'h0A5, 9'h0A5, 1'b0);
        push_and_see("gen_a5_odd", 1'b0, 1'b1, 9'h0A5, 9'h1A5, 1'b0);
        push_and_see("gen_07_even", 1'b0, 1'b0, 9'h007, 9'h107, 1'b0);
        push_and_see("gen_00_odd", 1'b0, 1'b1, 9'h000, 9'h100, 1'b0);
        push_and_see("gen_msb_ignored", 1'b0, 1'b0, 9'h1A5, 9'h0A5, 1'b0);
        check("gen_empty_level", 32'(level), 32'd0);
        check("gen_empty_data", 32'(out_data), 32'd0);

        // Check mode
        push_and_see("chk_1a5_odd", 1'b1, 1'b1, 9'h1A5, 9'h1A5, 1'b0);
        check("chk_cnt0", 32'(err_count), 32'd0);
        push_and_see("chk_1a5_even", 1'b1, 1'b0, 9'h1A5, 9'h1A5, 1'b1);
        check("chk_cnt1", 32'(err_count), 32'd1);
        push_and_see("chk_0a5_even", 1'b1, 1'b0, 9'h0A5, 9'h0A5, 1'b0);
        check("chk_cnt_hold", 32'(err_count), 32'd1);

        // Clear, then full / backpressure
        err_clr = 1'b1;
        @(posedge clk);
        #1;
        err_clr = 1'b0;
        check("clr_cnt", 32'(err_count), 32'd0);

        out_ready = 1'b0;
        chk_mode  = 1'b0;
        odd_sel   = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_data = words[i];
            check($sformatf("fill_ready_%0d", i), 32'(in_ready), 32'd1);
            @(posedge clk);
            #1;
            check($sformatf("fill_level_%0d", i), 32'(level), 32'(i + 1));
        end
        in_data = words[4];
        check("full_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        check("full_held_level", 32'(level), 32'd4);
        check("full_head", 32'(out_data), 32'(exp_w[0]));

        // First pop: 5th word still blocked this edge
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("pop1_level", 32'(level), 32'd3);
        check("pop1_head", 32'(out_data), 32'(exp_w[1]));
        check("pop1_in_ready", 32'(in_ready), 32'd1);
        // Pop + push of the 5th word together
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("pop2_level", 32'(level), 32'd3);
        for (int i = 2; i < 5; i++) begin
            check($sformatf("drain_head_%0d", i), 32'(out_data), 32'(exp_w[i]));
            check($sformatf("drain_level_max_%0d", i), 32'(level <= 3'd4), 32'd1);
            @(posedge clk);
            #1;
        end
        check("drain_empty", 32'(out_valid), 32'd0);

        // Saturation with CNT_W=2
        chk_mode = 1'b1;
        odd_sel  = 1'b0;
        in_data  = 9'h1A5;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("sat_cnt_%0d", i), 32'(err_count), 32'((i < 3) ? i + 1 : 3));
        end
        err_clr = 1'b1;
        @(posedge clk);
        #1;
        err_clr  = 1'b0;
        in_valid = 1'b0;
        check("sat_clr_priority", 32'(err_count), 32'd0);
        @(posedge clk);
        #1;
        check("sat_drained", 32'(level), 32'd0);

        // Reset mid-operation
        out_ready = 1'b0;
        push_one(1'b1, 1'b0, 9'h1A5);
        push_one(1'b0, 1'b0, 9'h007);
        check("mid_level", 32'(level), 32'd2);
        check("mid_cnt", 32'(err_count), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check("arst_level", 32'(level), 32'd0);
        check("arst_cnt", 32'(err_count), 32'd0);
        check("arst_in_ready", 32'(in_ready), 32'd1);
        check("arst_out_data", 32'(out_data), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        push_and_see("post_rst", 1'b0, 1'b0, 9'h0A5, 9'h0A5, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
